instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/instr_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the queue-entry layout and the PC increment helper.
package instr_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO buffering fetched {instr, pc} entries for the datapath.
// Flush empties it in one cycle; the head is read straight from storage.
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  entries_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = entries_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues in-order word requests, buffers responses in
// fetch_queue, and discards responses belonging to a path abandoned by redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   occupancy;
    logic [CW+1:0]   inflight_sum;
    logic            grant, rsp_any, rsp_push, rsp_drop, pop;
    logic            q_full, q_empty;
    fetch_entry_t    q_head, q_push_data;

    // Discarded responses still occupy a slot until they return, so they count against DEPTH.
    assign inflight_sum = {2'b00, outstanding_q} + {2'b00, discard_q} + {2'b00, occupancy};
    assign imem_req     = !rst && !redirect && (inflight_sum < (CW+2)'(DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign grant        = imem_req && imem_gnt;
    assign rsp_any      = imem_rvalid && ((discard_q != '0) || (outstanding_q != '0));
    assign rsp_drop     = imem_rvalid && (discard_q != '0);
    assign rsp_push     = imem_rvalid && (discard_q == '0) && (outstanding_q != '0)
                          && !redirect && !rst && !q_full;
    assign instr_valid  = !rst && !q_empty;
    assign pop          = instr_valid && instr_ready;
    assign q_push_data  = '{instr: imem_rdata, pc: resp_pc_q};

    always_comb begin
        if (q_empty) begin
            instr_code = 32'h0000_0000;
            instr_pc   = RESET_PC;
        end else begin
            instr_code = q_head.instr;
            instr_pc   = q_head.pc;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            resp_pc_d     = redirect_pc;
            outstanding_d = '0;
            // Everything still in flight, old path or older, is dropped on return.
            discard_d     = discard_q + outstanding_q - CW'(rsp_any);
        end else begin
            if (grant) begin
                fetch_pc_d = pc_inc(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_push) begin
                resp_pc_d = pc_inc(resp_pc_q);
            end else begin
                resp_pc_d = resp_pc_q;
            end
            case ({grant, rsp_push})
                2'b10:   outstanding_d = outstanding_q + CW'(1'b1);
                2'b01:   outstanding_d = outstanding_q - CW'(1'b1);
                default: outstanding_d = outstanding_q;
            endcase
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1'b1);
            end else begin
                discard_d = discard_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (rsp_push),
        .push_data (q_push_data),
        .pop       (pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (occupancy)
    );

endmodule
